// File: rtl/fir_pkg.sv
// Shared FIR definitions: FSM state encodings, tap count,
// history index type and modulo-NUM_TAP index helpers.
package fir_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int NUM_TAP = 11;
  localparam int IW      = $clog2(NUM_TAP);

  typedef logic [IW-1:0] idx_t;

  // Step an index, wrapping NUM_TAP-1 back to 0.
  function automatic idx_t wrap_inc(idx_t i);
    return (i == idx_t'(NUM_TAP-1)) ? '0 : i + idx_t'(1);
  endfunction

  // (a - b) mod NUM_TAP for a, b in 0..NUM_TAP-1.
  function automatic idx_t wrap_sub(idx_t a, idx_t b);
    return (a >= b) ? a - b : a + idx_t'(NUM_TAP) - b;
  endfunction

endpackage

// File: rtl/fir_addr_gen.sv
// History-buffer pointers (write, current, tap) and the
// BRAM byte addresses derived from them.
module fir_addr_gen
  import fir_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic          issue,
  input  logic          adv,
  output idx_t          k,
  output logic [AW-1:0] wr_a,
  output logic [AW-1:0] rd_a,
  output logic [AW-1:0] tap_a
);

  idx_t wp_q, wp_d;
  idx_t cur_q, cur_d;
  idx_t k_q, k_d;

  // Next-state for pointers; every wrap is explicit modulo NUM_TAP.
  always_comb begin
    wp_d  = wp_q;
    cur_d = cur_q;
    k_d   = k_q;
    if (clr)
      wp_d = '0;
    else if (adv)
      wp_d = wrap_inc(wp_q);
    if (load) begin
      cur_d = wp_q;
      k_d   = '0;
    end else if (issue) begin
      k_d = wrap_inc(k_q);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      cur_q <= '0;
      k_q   <= '0;
    end else begin
      wp_q  <= wp_d;
      cur_q <= cur_d;
      k_q   <= k_d;
    end
  end

  assign k     = k_q;
  assign wr_a  = AW'({wp_q, 2'b00});
  assign rd_a  = AW'({wrap_sub(cur_q, k_q), 2'b00});
  assign tap_a = AW'({k_q, 2'b00});

endmodule

// File: rtl/fir_mac_datapath.sv
// FIR datapath: circular sample history, pipelined MAC against
// the tap BRAM, and the AXI-Stream in/out handshakes.
module fir_mac_datapath
  import fir_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          axis_clk,
  input  logic          axis_rst_n,
  input  logic [2:0]    state,
  input  logic          ap_start,
  input  logic [DW-1:0] ss_tdata,
  input  logic          ss_tvalid,
  input  logic          ss_tlast,
  output logic          ss_tready,
  output logic [DW-1:0] sm_tdata,
  output logic          sm_tvalid,
  output logic          sm_tlast,
  input  logic          sm_tready,
  output logic          calc_done,
  output logic          last_r,
  output logic          tap_EN,
  output logic [AW-1:0] tap_A,
  input  logic [DW-1:0] tap_Do,
  output logic          data_EN,
  output logic [3:0]    data_WE,
  output logic [AW-1:0] data_A,
  output logic [DW-1:0] data_Di,
  input  logic [DW-1:0] data_Do
);

  logic clr, ld, iss, adv;
  logic in_load, in_calc, in_send;

  idx_t          k;
  logic [AW-1:0] wr_a, rd_a, tap_a;

  idx_t          fill_q, fill_d;
  logic          pipe_v_q, pipe_v_d;
  idx_t          pipe_k_q, pipe_k_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          last_r_q, last_r_d;
  logic [DW-1:0] prod;

  assign in_load = (state == S_LOAD);
  assign in_calc = (state == S_CALC);
  assign in_send = (state == S_SEND);

  assign clr = (state == S_IDLE) & ap_start;
  assign ld  = in_load & ss_tvalid;
  assign iss = in_calc & ~calc_done;
  assign adv = in_send & sm_tready;

  assign calc_done = pipe_v_q & (pipe_k_q == idx_t'(NUM_TAP-1));

  // Low DW bits of a product are identical for signed and unsigned.
  assign prod = tap_Do * data_Do;

  fir_addr_gen #(
    .AW (AW)
  ) u_addr (
    .clk   (axis_clk),
    .rst_n (axis_rst_n),
    .clr   (clr),
    .load  (ld),
    .issue (iss),
    .adv   (adv),
    .k     (k),
    .wr_a  (wr_a),
    .rd_a  (rd_a),
    .tap_a (tap_a)
  );

  // Fill level, MAC pipeline and accumulator next-state.
  always_comb begin
    fill_d   = fill_q;
    pipe_v_d = iss;
    pipe_k_d = iss ? k : pipe_k_q;
    acc_d    = acc_q;
    last_r_d = last_r_q;
    if (clr) begin
      fill_d   = '0;
      last_r_d = 1'b0;
    end
    if (ld) begin
      last_r_d = ss_tlast;
      acc_d    = '0;
      if (fill_q != idx_t'(NUM_TAP))
        fill_d = fill_q + idx_t'(1);
    end
    if (pipe_v_q && (pipe_k_q < fill_q))
      acc_d = acc_q + prod;
  end

  // Datapath registers.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      fill_q   <= '0;
      pipe_v_q <= 1'b0;
      pipe_k_q <= '0;
      acc_q    <= '0;
      last_r_q <= 1'b0;
    end else begin
      fill_q   <= fill_d;
      pipe_v_q <= pipe_v_d;
      pipe_k_q <= pipe_k_d;
      acc_q    <= acc_d;
      last_r_q <= last_r_d;
    end
  end

  assign last_r    = last_r_q;
  assign ss_tready = in_load;
  assign sm_tvalid = in_send;
  assign sm_tdata  = in_send ? acc_q : '0;
  assign sm_tlast  = in_send & last_r_q;

  assign tap_EN  = iss;
  assign tap_A   = iss ? tap_a : '0;
  assign data_EN = ld | iss;
  assign data_WE = ld ? 4'hF : 4'h0;
  assign data_A  = ld ? wr_a : (iss ? rd_a : '0);
  assign data_Di = ld ? ss_tdata : '0;

endmodule
